// File: rtl/dmem_bus_arbiter.sv
// Purpose: arbitrates the shared data-memory bus between the CPU MEM stage and a DMA engine.
// Latency: grant and bus drive are combinational in the request cycle; read data returns READ_LAT cycles later.
// Backpressure: a denied CPU sees cpu_stall; a denied DMA sees dma_gnt low and holds its request.
module dmem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t      state;
    logic [3:0]  starve_cnt;
    logic [3:0]  lock_cnt;
    logic        lock_ok;
    logic        dma_win;
    logic        cpu_win;
    logic        rd_issue;
    logic        tail_vld;
    logic        tail_dma;

    // Read-return pipeline: valid bit plus owner (1 = DMA) per outstanding read slot.
    logic [READ_LAT-1:0] rd_vld;
    logic [READ_LAT-1:0] rd_own;

    // Grant decision: CPU by default, DMA when CPU idle, starved, or holding a bounded lock.
    always_comb begin
        lock_ok = (state == DMA_OWN) && dma_lock && (lock_cnt < MAX_W);
        dma_win = !reset && dma_req && (!cpu_req || (starve_cnt == MAX_W) || lock_ok);
        cpu_win = !reset && cpu_req && !dma_win;
    end

    // Bus mux from the granted port; everything is zero when nobody owns the bus.
    always_comb begin
        mem_en    = dma_win || cpu_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_win) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_win) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
        rd_issue  = mem_en && !mem_we;
        dma_gnt   = dma_win;
        cpu_stall = !reset && cpu_req && !cpu_win;
    end

    // Route returning read data to whichever port issued the read; the other port sees zero.
    always_comb begin
        tail_vld   = rd_vld[READ_LAT-1] && !reset;
        tail_dma   = rd_own[READ_LAT-1];
        cpu_rvalid = tail_vld && !tail_dma;
        dma_rvalid = tail_vld && tail_dma;
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dma_rdata  = dma_rvalid ? mem_rdata : '0;
    end

    // Owner FSM, starvation/lock counters and read-return shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            rd_vld     <= '0;
            rd_own     <= '0;
        end else begin
            if (dma_win)
                state <= DMA_OWN;
            else if (cpu_win)
                state <= CPU_OWN;
            else
                state <= IDLE;

            // Counts DMA cycles lost to the CPU; hitting MAX_W forces one DMA grant.
            if (dma_win || !dma_req)
                starve_cnt <= '0;
            else if (cpu_win && (starve_cnt < MAX_W))
                starve_cnt <= starve_cnt + 4'd1;

            // Counts DMA cycles taken while the CPU is waiting, bounding a locked burst.
            if (cpu_win || !dma_req)
                lock_cnt <= '0;
            else if (dma_win && cpu_req && (lock_cnt < MAX_W))
                lock_cnt <= lock_cnt + 4'd1;

            for (int i = READ_LAT - 1; i > 0; i--) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_own[i] <= rd_own[i-1];
            end
            rd_vld[0] <= rd_issue;
            rd_own[0] <= dma_win;
        end
    end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: two instances (READ_LAT=1 and READ_LAT=2) share stimulus.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_dmem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

    logic        u1_cpu_stall, u1_cpu_rvalid, u1_dma_gnt, u1_dma_rvalid, u1_mem_en, u1_mem_we;
    logic [31:0] u1_cpu_rdata, u1_dma_rdata, u1_mem_addr, u1_mem_wdata;
    logic        u2_cpu_stall, u2_cpu_rvalid, u2_dma_gnt, u2_dma_rvalid, u2_mem_en, u2_mem_we;
    logic [31:0] u2_cpu_rdata, u2_dma_rdata, u2_mem_addr, u2_mem_wdata;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .READ_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(u1_cpu_stall), .cpu_rvalid(u1_cpu_rvalid), .cpu_rdata(u1_cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(u1_dma_gnt), .dma_rvalid(u1_dma_rvalid),
        .dma_rdata(u1_dma_rdata), .mem_en(u1_mem_en), .mem_we(u1_mem_we),
        .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .READ_LAT(2)) u2 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(u2_cpu_stall), .cpu_rvalid(u2_cpu_rvalid), .cpu_rdata(u2_cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(u2_dma_gnt), .dma_rvalid(u2_dma_rvalid),
        .dma_rdata(u2_dma_rdata), .mem_en(u2_mem_en), .mem_we(u2_mem_we),
        .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
        mem_rdata = 0;
    endtask

    initial begin
        // Reset with both requesters asserted: every output must stay quiet.
        reset = 1;
        idle_inputs();
        cpu_req = 1; dma_req = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        @(negedge clk);
        chk("rst_cpu_stall", {31'b0, u1_cpu_stall}, 0);
        chk("rst_dma_gnt", {31'b0, u1_dma_gnt}, 0);
        chk("rst_mem_en", {31'b0, u1_mem_en}, 0);
        chk("rst_mem_addr", u1_mem_addr, 0);
        chk("rst_cpu_rdata", u1_cpu_rdata, 0);

        // CPU-only read, READ_LAT=1.
        tick();
        reset = 0;
        idle_inputs();
        cpu_req = 1; cpu_addr = 32'h4000_0010;
        @(negedge clk);
        chk("t1_mem_en", {31'b0, u1_mem_en}, 1);
        chk("t1_cpu_stall", {31'b0, u1_cpu_stall}, 0);
        chk("t1_mem_addr", u1_mem_addr, 32'h4000_0010);
        tick();
        cpu_req = 0; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_cpu_rvalid", {31'b0, u1_cpu_rvalid}, 1);
        chk("t1_cpu_rdata", u1_cpu_rdata, 32'hDEAD_BEEF);
        chk("t1_dma_rvalid", {31'b0, u1_dma_rvalid}, 0);
        chk("t1_dma_rdata", u1_dma_rdata, 0);
        tick();
        idle_inputs();
        tick();

        // Contention: CPU for four cycles, starvation forces DMA once, then CPU again.
        cpu_req = 1; cpu_we = 1; dma_req = 1; dma_we = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("t2_dma_gnt_c%0d", c), {31'b0, u1_dma_gnt}, (c == 4) ? 1 : 0);
            chk($sformatf("t2_cpu_stall_c%0d", c), {31'b0, u1_cpu_stall}, (c == 4) ? 1 : 0);
            tick();
        end
        idle_inputs();
        tick();

        // Locked DMA burst with the CPU idle: granted every cycle.
        dma_req = 1; dma_we = 1; dma_lock = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t3a_dma_gnt_c%0d", c), {31'b0, u1_dma_gnt}, 1);
            tick();
        end
        idle_inputs();
        tick();

        // Locked burst with CPU arriving at cycle 2: lock lasts four more cycles, CPU wins cycle 6.
        dma_req = 1; dma_we = 1; dma_lock = 1;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) begin
                cpu_req = 1; cpu_we = 1;
            end
            @(negedge clk);
            chk($sformatf("t3b_dma_gnt_c%0d", c), {31'b0, u1_dma_gnt}, (c <= 5) ? 1 : 0);
            chk($sformatf("t3b_cpu_stall_c%0d", c), {31'b0, u1_cpu_stall},
                (c >= 2 && c <= 5) ? 1 : 0);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // Read routing with READ_LAT=2: CPU read cycle 0, DMA read cycle 1.
        cpu_req = 1; cpu_addr = 32'h0000_0100;
        @(negedge clk);
        chk("t4_c0_mem_en", {31'b0, u2_mem_en}, 1);
        tick();
        cpu_req = 0; dma_req = 1; dma_addr = 32'h0000_0200;
        @(negedge clk);
        chk("t4_c1_dma_gnt", {31'b0, u2_dma_gnt}, 1);
        chk("t4_c1_cpu_rvalid", {31'b0, u2_cpu_rvalid}, 0);
        tick();
        dma_req = 0; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("t4_c2_cpu_rvalid", {31'b0, u2_cpu_rvalid}, 1);
        chk("t4_c2_cpu_rdata", u2_cpu_rdata, 32'h1111_1111);
        chk("t4_c2_dma_rvalid", {31'b0, u2_dma_rvalid}, 0);
        tick();
        mem_rdata = 32'h2222_2222;
        @(negedge clk);
        chk("t4_c3_dma_rvalid", {31'b0, u2_dma_rvalid}, 1);
        chk("t4_c3_dma_rdata", u2_dma_rdata, 32'h2222_2222);
        chk("t4_c3_cpu_rvalid", {31'b0, u2_cpu_rvalid}, 0);
        chk("t4_c3_cpu_rdata", u2_cpu_rdata, 0);
        tick();
        mem_rdata = 32'h3333_3333;
        @(negedge clk);
        chk("t4_c4_dma_rvalid", {31'b0, u2_dma_rvalid}, 0);
        chk("t4_c4_cpu_rvalid", {31'b0, u2_cpu_rvalid}, 0);
        tick();
        idle_inputs();
        tick();

        // Reset mid-operation: DMA read in flight is dropped, FSM back to IDLE.
        dma_req = 1; dma_lock = 1; dma_addr = 32'h0000_0300;
        @(negedge clk);
        chk("t5_c0_dma_gnt", {31'b0, u1_dma_gnt}, 1);
        tick();
        reset = 1; dma_req = 0; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t5_rst_dma_rvalid", {31'b0, u1_dma_rvalid}, 0);
        chk("t5_rst_dma_rdata", u1_dma_rdata, 0);
        chk("t5_rst_mem_en", {31'b0, u1_mem_en}, 0);
        tick();
        reset = 0; cpu_req = 1; dma_req = 1; dma_lock = 1;
        @(negedge clk);
        chk("t5_post_u2_dma_rvalid", {31'b0, u2_dma_rvalid}, 0);
        chk("t5_post_cpu_stall", {31'b0, u1_cpu_stall}, 0);
        chk("t5_post_dma_gnt", {31'b0, u1_dma_gnt}, 0);
        tick();
        idle_inputs();
        tick();
        tick();

        // DMA write with the CPU idle.
        dma_req = 1; dma_we = 1; dma_addr = 32'h4000_0018; dma_wdata = 32'h55;
        @(negedge clk);
        chk("t6_mem_en", {31'b0, u1_mem_en}, 1);
        chk("t6_mem_we", {31'b0, u1_mem_we}, 1);
        chk("t6_mem_addr", u1_mem_addr, 32'h4000_0018);
        chk("t6_mem_wdata", u1_mem_wdata, 32'h55);
        chk("t6_dma_gnt", {31'b0, u1_dma_gnt}, 1);
        tick();
        idle_inputs();
        mem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("t6_c1_mem_en", {31'b0, u1_mem_en}, 0);
        chk("t6_c1_mem_addr", u1_mem_addr, 0);
        chk("t6_c1_u1_dma_rvalid", {31'b0, u1_dma_rvalid}, 0);
        tick();
        @(negedge clk);
        chk("t6_c2_u2_dma_rvalid", {31'b0, u2_dma_rvalid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
Arbitrates the single data-memory/peripheral bus between the pipeline MEM stage (CPU port) and a UART/peripheral DMA engine (DMA port). CPU has default priority. A starvation counter forces DMA service after MAX_WAIT lost cycles. A DMA lock mode gives back-to-back DMA bursts. Read data from the fixed-latency memory is routed back to the requester that issued the read. `cpu_stall` feeds the hazard unit so that the whole pipeline freezes while the CPU port is denied.

Parameters:
ADDR_W, 32, address width of both ports and the memory bus
DATA_W, 32, data width
MAX_WAIT, 4, consecutive DMA-denied cycles before DMA is forced priority (1..15)
READ_LAT, 1, memory read latency in cycles, mem_rdata valid READ_LAT cycles after the read is issued (1..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  MEM stage access request (MemRd|MemWr)
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU request not granted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
dma_req  in  1  DMA access request
dma_we  in  1  1=write, 0=read
dma_lock  in  1  keep DMA ownership while dma_req stays high
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA request accepted this cycle
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DATA_W  DMA read data
mem_en  out  1  bus access strobe
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Owner FSM: states IDLE, CPU_OWN, DMA_OWN. The state records the grant of the previous cycle.
- Grant decision (combinational from inputs, FSM state and starve_cnt):
  - `reset` high: no grant.
  - Else grant DMA if dma_req && (!cpu_req || starve_cnt==MAX_WAIT || (state==DMA_OWN && dma_lock)).
  - Else grant CPU if cpu_req.
  - Else no grant.
- Bus outputs:
  - mem_en=1 whenever a grant is made.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port.
  - With no grant, all mem_* outputs are 0.
- Handshake outputs:
  - dma_gnt = DMA granted.
  - cpu_stall = cpu_req && !CPU granted.
  - The requester holds req and its fields stable until granted; the CPU is held by the stall.
- Next state: DMA_OWN if DMA granted, CPU_OWN if CPU granted, otherwise IDLE.
- starve_cnt (4-bit):
  - Increments when dma_req && CPU granted, saturating at MAX_WAIT.
  - Cleared to 0 when DMA is granted or when dma_req is low.
- Lock bound: a locked DMA burst is unbounded only while cpu_req is low. With cpu_req high, lock holds for at most MAX_WAIT further cycles.
  - A lock-cycle counter, cleared on any CPU grant, then returns the bus to the CPU for ≥1 cycle.
- Read return:
  - READ_LAT-deep shift register of {valid, owner} is loaded on each granted read (mem_en && !mem_we).
  - At the tail: if owner=CPU, cpu_rvalid=1 and cpu_rdata=mem_rdata. If owner=DMA, dma_rvalid=1 and dma_rdata=mem_rdata.
  - The rdata output of the non-addressed port is 0.
  - Writes produce no rvalid.
- Back-to-back reads of alternating owners each return in their own cycle; there is no reordering.
- Reset:
  - The synchronous `reset` clears the FSM to IDLE, starve_cnt and the lock counter to 0, and the shift register to all invalid.
  - While reset is high all outputs are 0: cpu_stall=0, dma_gnt=0, rvalids=0, rdata=0, mem_*=0.
  - Reads in flight when reset asserts are discarded; no rvalid is produced after reset.
- Simultaneous first requests from IDLE with starve_cnt=0: CPU wins.

Test Plan:
1. CPU-only read: READ_LAT=1, cpu_req=1, cpu_we=0, addr=0x40000010, mem_rdata=0xDEADBEEF -> mem_en=1, cpu_stall=0 in cycle 0; cpu_rvalid=1, cpu_rdata=0xDEADBEEF in cycle 1.
2. Contention and starvation: cpu_req and dma_req held high continuously, MAX_WAIT=4 -> CPU granted in cycles 0–3, DMA granted in cycle 4 with cpu_stall=1 there, then CPU again in cycle 5.
3. DMA lock burst: cpu_req=0, dma_lock=1, dma_req held 8 cycles -> dma_gnt=1 for all 8 cycles. If cpu_req rises at cycle 2, CPU is granted no later than cycle 7.
4. Read routing: READ_LAT=2, CPU read in cycle 0 and DMA read in cycle 1 -> cpu_rvalid only in cycle 2, dma_rvalid only in cycle 3, with correct data on each.
5. Reset mid-operation: DMA read granted in cycle 0, reset high in cycle 1 -> no dma_rvalid afterwards, all outputs 0 during reset, FSM returns to IDLE.
6. Write: dma_req=1, dma_we=1, addr=0x40000018, wdata=0x55 with cpu idle -> mem_we=1 and the bus carries the DMA fields for one cycle; no rvalid follows.
